// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   INSTR_W           instruction width
//   RESET_PC_DEFAULT  default PC after reset
//   fetch_state_e     fetch FSM states
//   fetch_act_e       per-cycle action chosen by the next-PC selector
//   branch_target()   PC-relative target of a beq/bne
//   jump_target()     region-relative target of a j
package cpu_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN,
      HALTED
   } fetch_state_e;

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_LOAD,
      ACT_REDIRECT,
      ACT_HALT
   } fetch_act_e;

   // pc is the address of the branch instruction itself; offset is relative to pc+4.
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [15:0] imm16);
      logic [31:0] pc4;
      pc4 = pc + 32'd4;
      return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

   // The 256 MB region comes from pc+4, not pc, so a j in the last slot of a region
   // lands in the next one.
   function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                               input logic [25:0] tgt26);
      logic [31:0] pc4;
      pc4 = pc + 32'd4;
      return {pc4[31:28], tgt26, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selector for the fetch stage (purely combinational).
//   pc_q         current fetch address
//   instr_pc     address of the held instruction
//   instr_valid  held instruction valid
//   instr_ready  decoder consumes the held instruction
//   branch_taken / branch_imm, jump / jump_target, halt
//                redirect controls, only meaningful on a handshake
//   pc_next      PC to load on the next edge
//   act          what the registers should do this cycle
module fetch_next_pc
   import cpu_pkg::*;
(
   input  logic [31:0] pc_q,
   input  logic [31:0] instr_pc,
   input  logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        halt,
   output logic [31:0] pc_next,
   output fetch_act_e  act
);

   logic hs;

   assign hs = instr_valid & instr_ready;

   // Priority: halt > jump > branch > sequential load > stall.
   always_comb begin
      pc_next = pc_q;
      act     = ACT_HOLD;
      if (hs && halt) begin
         act = ACT_HALT;
      end else if (hs && jump) begin
         act     = ACT_REDIRECT;
         pc_next = cpu_pkg::jump_target(instr_pc, jump_target);
      end else if (hs && branch_taken) begin
         act     = ACT_REDIRECT;
         pc_next = cpu_pkg::branch_target(instr_pc, branch_imm);
      end else if (!instr_valid || instr_ready) begin
         act     = ACT_LOAD;
         pc_next = pc_q + 32'd4;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage in front of the instruction ROM.
//   clk, rst_n        clock, async active-low reset
//   rom_addr          ROM byte address (always pc_q)
//   rom_data          ROM word, same-cycle
//   instr, instr_pc   held instruction and its address
//   instr_valid       held instruction valid
//   instr_ready       decoder consumes the held instruction
//   branch_taken, branch_imm, jump, jump_target, halt
//                     redirects from the decoder, sampled on handshake
//   halted            fetch has stopped until reset
//   retired_cnt       handshakes since reset (wraps)
//
// state  | meaning
// -------+-----------------------------------------------------
// RUN    | fetching; loads, stalls or redirects each cycle
// HALTED | halt consumed; everything frozen until rst_n
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               branch_taken,
   input  logic [15:0]        branch_imm,
   input  logic               jump,
   input  logic [25:0]        jump_target,
   input  logic               halt,
   output logic               halted,
   output logic [CNT_W-1:0]   retired_cnt
);

   fetch_state_e       state_q, state_d;
   logic [31:0]        pc_q, pc_d, pc_next;
   logic [INSTR_W-1:0] instr_d;
   logic [31:0]        instr_pc_d;
   logic               valid_d;
   logic [CNT_W-1:0]   cnt_d;
   fetch_act_e         act;
   logic               hs;

   fetch_next_pc u_next_pc (
      .pc_q         (pc_q),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_target  (jump_target),
      .halt         (halt),
      .pc_next      (pc_next),
      .act          (act)
   );

   assign rom_addr = pc_q;
   assign halted   = (state_q == HALTED);
   assign hs       = instr_valid & instr_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr;
      instr_pc_d = instr_pc;
      valid_d    = instr_valid;
      case (state_q)
         RUN: begin
            case (act)
               ACT_HALT: begin
                  valid_d = 1'b0;
                  state_d = HALTED;
               end
               ACT_REDIRECT: begin
                  valid_d = 1'b0;
                  pc_d    = pc_next;
               end
               ACT_LOAD: begin
                  instr_d    = rom_data;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  pc_d       = pc_next;
               end
               ACT_HOLD: begin
               end
            endcase
         end
         HALTED: begin
            valid_d = 1'b0;
         end
      endcase
   end

   // instr_valid is 0 in HALTED, so no handshake can be counted there.
   assign cnt_d = hs ? retired_cnt + CNT_W'(1) : retired_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         retired_cnt <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr       <= instr_d;
         instr_pc    <= instr_pc_d;
         instr_valid <= valid_d;
         retired_cnt <= cnt_d;
      end
   end

endmodule
